// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the multicycle ALU:
//   alu_op_e  - 4-bit ALU operation codes issued by ALU control
//   state_e   - states of the iterative MUL/DIV engine
//   CNT_W     - iteration counter width for the default 32-bit datapath
//   cntWidth  - counter width for an arbitrary datapath width
// Optional feature macro (consumed by the modules): ALU_HILO_EN
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_MUL = 4'b0011,
    OP_DIV = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_NOR = 4'b0111,
    OP_SLT = 4'b1000,
    OP_XOR = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    FINISH
  } state_e;

  localparam int ALU_WIDTH = 32;
  localparam int CNT_W     = $clog2(ALU_WIDTH);

  // Counter width needed to count WIDTH-1 down to 0.
  function automatic int cntWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Iterative signed multiply / divide engine. Works on operand magnitudes,
// one shift-add (MUL) or restoring-subtract (DIV) step per cycle, and applies
// the sign fix-up combinationally while in FINISH so the parent can register
// the final values on the edge that leaves FINISH.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           accepted MUL/DIV this cycle (only honoured in IDLE)
//   isDiv           1 = DIV, 0 = MUL (sampled with start)
//   a, b            signed operands (sampled with start)
//   busy            engine not idle (registered state decode)
//   finish          engine in FINISH; seqResult/seqHi/seqDbz are final
//   seqResult       signed product low half / signed quotient
//   seqHi           product high half / signed remainder (ALU_HILO_EN only)
//   seqDbz          division by zero detected
// Macro: ALU_HILO_EN builds the upper product half and exposes seqHi.
// ---------------------------------------------------------------------------
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] seqResult,
`ifdef ALU_HILO_EN
  output logic [WIDTH-1:0] seqHi,
`endif
  output logic             seqDbz
);

  localparam int CW = cntWidth(WIDTH);

  state_e           stateReg;
  logic [CW-1:0]    cntReg;
  // upperReg: product high half (HILO) / W-bit accumulator (no HILO) / remainder
  logic [WIDTH-1:0] upperReg;
  // shReg: multiplier shifting out (and product low half with HILO) / dividend-quotient
  logic [WIDTH-1:0] shReg;
  // operandReg: multiplicand or divisor magnitude
  logic [WIDTH-1:0] operandReg;
  logic             isDivReg;
  logic             negResReg;
  logic             dbzReg;
`ifdef ALU_HILO_EN
  logic             negHiReg;
`endif

  logic [WIDTH-1:0] absA, absB, addend;
  logic [WIDTH:0]   divShift, divTrial;
  logic             divFits;

  assign absA   = a[WIDTH-1] ? -a : a;
  assign absB   = b[WIDTH-1] ? -b : b;
  assign addend = shReg[0] ? operandReg : '0;

  // Restoring division: shift the next dividend bit into the partial remainder
  // and keep the subtraction only if it does not go negative.
  assign divShift = {upperReg, shReg[WIDTH-1]};
  assign divTrial = divShift - {1'b0, operandReg};
  assign divFits  = ~divTrial[WIDTH];

`ifdef ALU_HILO_EN
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   prodMag, prodSigned;
  assign mulSum     = {1'b0, upperReg} + {1'b0, addend};
  assign prodMag    = {upperReg, shReg};
  assign prodSigned = negResReg ? -prodMag : prodMag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      upperReg   <= '0;
      shReg      <= '0;
      operandReg <= '0;
      isDivReg   <= 1'b0;
      negResReg  <= 1'b0;
      dbzReg     <= 1'b0;
`ifdef ALU_HILO_EN
      negHiReg   <= 1'b0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            isDivReg  <= isDiv;
            negResReg <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_HILO_EN
            negHiReg  <= a[WIDTH-1];
`endif
            dbzReg    <= 1'b0;
            cntReg    <= CW'(WIDTH - 1);
            if (isDiv) begin
              if (b == '0) begin
                // No iterations: FINISH reports all ones and a as remainder.
                dbzReg   <= 1'b1;
                upperReg <= a;
                stateReg <= FINISH;
              end else begin
                upperReg   <= '0;
                shReg      <= absA;
                operandReg <= absB;
                stateReg   <= DIV_RUN;
              end
            end else begin
              upperReg   <= '0;
              shReg      <= absB;
              operandReg <= absA;
              stateReg   <= MUL_RUN;
            end
          end
        end
        MUL_RUN: begin
`ifdef ALU_HILO_EN
          // Right-shifting 2W-bit product: sum drops into the top half.
          upperReg <= mulSum[WIDTH:1];
          shReg    <= {mulSum[0], shReg[WIDTH-1:1]};
`else
          // W-bit accumulator: multiplicand moves left, multiplier moves right.
          upperReg   <= upperReg + addend;
          operandReg <= operandReg << 1;
          shReg      <= shReg >> 1;
`endif
          if (cntReg == '0) stateReg <= FINISH;
          else              cntReg   <= cntReg - CW'(1);
        end
        DIV_RUN: begin
          upperReg <= divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
          shReg    <= {shReg[WIDTH-2:0], divFits};
          if (cntReg == '0) stateReg <= FINISH;
          else              cntReg   <= cntReg - CW'(1);
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (stateReg != IDLE);
  assign finish = (stateReg == FINISH);
  assign seqDbz = dbzReg;

  // Sign fix-up of the magnitude results.
  always_comb begin
    seqResult = '0;
`ifdef ALU_HILO_EN
    seqHi     = '0;
`endif
    if (dbzReg) begin
      seqResult = '1;
`ifdef ALU_HILO_EN
      seqHi     = upperReg;
`endif
    end else if (isDivReg) begin
      seqResult = negResReg ? -shReg : shReg;
`ifdef ALU_HILO_EN
      seqHi     = negHiReg ? -upperReg : upperReg;
`endif
    end else begin
`ifdef ALU_HILO_EN
      seqResult = prodSigned[WIDTH-1:0];
      seqHi     = prodSigned[2*WIDTH-1:WIDTH];
`else
      seqResult = negResReg ? -upperReg : upperReg;
`endif
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// EX-stage ALU. Logic, ADD/SUB and SLT complete in one cycle; MUL and DIV are
// handed to the iterative engine and report WIDTH+1 cycles after acceptance.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   op_valid      alu_op/a/b valid; accepted when op_valid && in_ready
//   in_ready      !busy
//   alu_op        4-bit operation code (see alu_pkg::alu_op_e)
//   a, b          two's complement operands
//   res_valid     one-cycle pulse when result/flags update
//   result        registered result, held between pulses
//   zero          result == 0
//   ovf           signed overflow for ADD/SUB
//   div_by_zero   DIV with b == 0
//   busy          MUL/DIV in progress
//   hi            product upper half / remainder (ALU_HILO_EN), else 0
// Macro: ALU_HILO_EN enables the hi register.
// ---------------------------------------------------------------------------
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div_by_zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi
);

  alu_op_e          opCode;
  logic             accept, isMulDiv, seqStart;
  logic             seqBusy, seqFinish, seqDbz;
  logic [WIDTH-1:0] seqResult;
  logic [WIDTH-1:0] sumAB, diffAB, aluRes;
  logic             aluOvf;

  logic [WIDTH-1:0] resultReg;
  logic             zeroReg, ovfReg, dbzReg, resValidReg;

  assign opCode   = alu_op_e'(alu_op);
  assign in_ready = ~seqBusy;
  assign busy     = seqBusy;
  assign accept   = op_valid & in_ready;
  assign isMulDiv = (opCode == OP_MUL) || (opCode == OP_DIV);
  assign seqStart = accept & isMulDiv;

`ifdef ALU_HILO_EN
  logic [WIDTH-1:0] seqHi;
  logic [WIDTH-1:0] hiReg;
`endif

  alu_muldiv_seq #(.WIDTH(WIDTH)) uSeq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (seqStart),
    .isDiv     (opCode == OP_DIV),
    .a         (a),
    .b         (b),
    .busy      (seqBusy),
    .finish    (seqFinish),
    .seqResult (seqResult),
`ifdef ALU_HILO_EN
    .seqHi     (seqHi),
`endif
    .seqDbz    (seqDbz)
  );

  assign sumAB  = a + b;
  assign diffAB = a - b;

  // Single-cycle datapath; undefined codes and MUL/DIV fall to zero here.
  always_comb begin
    aluRes = '0;
    aluOvf = 1'b0;
    case (opCode)
      OP_ADD: begin
        aluRes = sumAB;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sumAB[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Subtraction adds ~b+1, so overflow needs a and b of opposite sign.
        aluRes = diffAB;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diffAB[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  aluRes = a & b;
      OP_OR:   aluRes = a | b;
      OP_NOR:  aluRes = ~(a | b);
      OP_XOR:  aluRes = a ^ b;
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: aluRes = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultReg   <= '0;
      zeroReg     <= 1'b0;
      ovfReg      <= 1'b0;
      dbzReg      <= 1'b0;
      resValidReg <= 1'b0;
`ifdef ALU_HILO_EN
      hiReg       <= '0;
`endif
    end else begin
      resValidReg <= 1'b0;
      if (seqFinish) begin
        resultReg   <= seqResult;
        zeroReg     <= (seqResult == '0);
        ovfReg      <= 1'b0;
        dbzReg      <= seqDbz;
        resValidReg <= 1'b1;
`ifdef ALU_HILO_EN
        hiReg       <= seqHi;
`endif
      end else if (accept && !isMulDiv) begin
        resultReg   <= aluRes;
        zeroReg     <= (aluRes == '0);
        ovfReg      <= aluOvf;
        dbzReg      <= 1'b0;
        resValidReg <= 1'b1;
      end
    end
  end

  assign result      = resultReg;
  assign zero        = zeroReg;
  assign ovf         = ovfReg;
  assign div_by_zero = dbzReg;
  assign res_valid   = resValidReg;
`ifdef ALU_HILO_EN
  assign hi = hiReg;
`else
  assign hi = '0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
// Directed and random transactions against a reference model that computes
// results with 64-bit signed arithmetic. Honours ALU_HILO_EN for hi.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, res_valid, zero, ovf, div_by_zero, busy;
  logic [W-1:0] result, hi;

  int testCount = 0;
  int failCount = 0;
  logic [W-1:0] hiModel = '0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .result      (result),
    .zero        (zero),
    .ovf         (ovf),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .hi          (hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the arithmetic rules, not the hardware steps.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic ov, output logic dz,
                       output logic [W-1:0] h, output int lat);
    longint sx, sy, wide, q, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; ov = 1'b0; dz = 1'b0; h = hiModel; lat = 0;
    case (op)
      4'd1: begin wide = sx + sy; r = wide[W-1:0]; ov = (wide > MAX_S) || (wide < MIN_S); end
      4'd2: begin wide = sx - sy; r = wide[W-1:0]; ov = (wide > MAX_S) || (wide < MIN_S); end
      4'd3: begin wide = sx * sy; r = wide[W-1:0]; h = wide[2*W-1:W]; lat = W + 1; end
      4'd4: begin
        if (y == '0) begin
          r = '1; h = x; dz = 1'b1; lat = 1;
        end else begin
          q = sx / sy; rm = sx % sy;
          r = q[W-1:0]; h = rm[W-1:0]; lat = W + 1;
        end
      end
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = ~(x | y);
      4'd8: r = (sx < sy) ? 1 : 0;
      4'd9: r = x ^ y;
      default: r = '0;
    endcase
`ifndef ALU_HILO_EN
    h = '0;
`endif
  endtask

  task automatic runOp(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit intrude);
    logic [W-1:0] er, eh;
    logic eo, ed;
    int el, edges, busyCnt;
    model(op, x, y, er, eo, ed, eh, el);
    @(negedge clk);
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    alu_op = op; a = x; b = y; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    // Scramble operands: the DUT must have sampled them already.
    a = $urandom; b = $urandom; alu_op = 4'($urandom);
    edges = 0; busyCnt = 0;
    @(negedge clk);
    while (!res_valid && edges < 100) begin
      if (busy) busyCnt++;
      if (intrude && edges == 5) begin
        check("in_ready_while_busy", {63'd0, in_ready}, 64'd0);
        alu_op = 4'd1; a = 32'd1; b = 32'd1; op_valid = 1'b1;
      end
      if (intrude && edges == 8) op_valid = 1'b0;
      @(negedge clk);
      edges++;
    end
    op_valid = 1'b0;
    check("latency", 64'(edges), 64'(el));
    check("busy_cycles", 64'(busyCnt), 64'(el));
    check("result", {32'd0, result}, {32'd0, er});
    check("zero", {63'd0, zero}, {63'd0, (er == '0)});
    check("ovf", {63'd0, ovf}, {63'd0, eo});
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
    check("hi", {32'd0, hi}, {32'd0, eh});
    hiModel = eh;
    $display("[TB] op=%h a=%h b=%h -> result=%h hi=%h ovf=%0d dbz=%0d lat=%0d",
             op, x, y, result, hi, ovf, div_by_zero, edges);
    @(negedge clk);
    check("res_valid_pulse", {63'd0, res_valid}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return MIN_V;
      2: return '1;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    #12;
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_flags", {61'd0, zero, ovf, div_by_zero}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    runOp(4'd1, 32'd7, -32'sd3, 1'b0);
    runOp(4'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runOp(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0);
    runOp(4'd3, -32'sd6, 32'd7, 1'b1);
    runOp(4'd4, -32'sd7, 32'd2, 1'b0);
    runOp(4'd4, 32'd5, 32'd0, 1'b0);
    runOp(4'd1, 32'd5, -32'sd5, 1'b0);
    runOp(4'd4, MIN_V, 32'hFFFF_FFFF, 1'b0);
    runOp(4'd3, MIN_V, MIN_V, 1'b0);
    runOp(4'd7, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
    runOp(4'd15, 32'd3, 32'd4, 1'b0);

    // Reset in the middle of a DIV
    runOp(4'd9, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    alu_op = 4'd4; a = -32'sd100; b = 32'd7; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("div_busy_before_reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_res_valid", {63'd0, res_valid}, 64'd0);
    check("midrst_flags", {61'd0, zero, ovf, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hiModel = '0;
    runOp(4'd1, 32'd1, 32'd1, 1'b0);

    // Random transactions
    for (int n = 0; n < 60; n++) begin
      runOp(4'($urandom_range(0, 15)), pick(), pick(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
